// File: rtl/ycc2rgb_ser.sv
// YCbCr to RGB converter with a 2-stage pipeline, pixel FIFO and R,G,B byte serializer.
// Optional macro YCC2RGB_GRAY_EN: output R=G=B=Y with no multipliers, same timing.
module ycc2rgb_ser #(
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          CLOCK,
  input  logic          RST,
  input  logic          YCC_VSYNC,
  input  logic          YCC_DVALID,
  input  logic [DW-1:0] Y_DAT,
  input  logic [DW-1:0] Cb_DAT,
  input  logic [DW-1:0] Cr_DAT,
  output logic          YCC_READY,
  output logic          IMG_DVSYN,
  output logic          IMG_DHSYN,
  output logic [DW-1:0] IMG_DVD
);

  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned PXW = 3 * DW;

  typedef enum logic [1:0] {IDLE, SR, SG, SB} state_t;

  logic           accept;
  logic           s1_v;
  logic [PXW-1:0] push_px;

  assign accept = YCC_DVALID & YCC_READY & YCC_VSYNC;

`ifdef YCC2RGB_GRAY_EN
  logic [DW-1:0] s1_y;
  logic          unused_chroma;

  assign unused_chroma = ^{Cb_DAT, Cr_DAT};

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      s1_v <= 1'b0;
      s1_y <= '0;
    end else begin
      s1_v <= accept;
      if (accept) s1_y <= Y_DAT;
    end
  end

  assign push_px = {s1_y, s1_y, s1_y};
`else
  // Q8 fixed-point coefficients; intermediate wide enough for 256*Y plus the largest chroma term.
  localparam int unsigned IW = DW + 11;
  localparam logic signed [IW-1:0] OFS   = IW'(2 ** (DW - 1));
  localparam logic signed [IW-1:0] MAXS  = IW'((2 ** DW) - 1);
  localparam logic signed [IW-1:0] K_RCR = IW'(359);
  localparam logic signed [IW-1:0] K_GCB = IW'(88);
  localparam logic signed [IW-1:0] K_GCR = IW'(183);
  localparam logic signed [IW-1:0] K_BCB = IW'(454);

  logic signed [IW-1:0] y_in, cb_in, cr_in;
  logic signed [IW-1:0] s1_y, s1_rcr, s1_gcb, s1_gcr, s1_bcb;
  logic signed [IW-1:0] r_sum, g_sum, b_sum;

  function automatic logic [DW-1:0] clamp(input logic signed [IW-1:0] v);
    if (v[IW-1])      clamp = '0;
    else if (v > MAXS) clamp = '1;
    else               clamp = v[DW-1:0];
  endfunction

  assign y_in  = $signed(IW'(Y_DAT)) <<< 8;
  assign cb_in = $signed(IW'(Cb_DAT)) - OFS;
  assign cr_in = $signed(IW'(Cr_DAT)) - OFS;

  // Stage 1: register the products.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      s1_v   <= 1'b0;
      s1_y   <= '0;
      s1_rcr <= '0;
      s1_gcb <= '0;
      s1_gcr <= '0;
      s1_bcb <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_y   <= y_in;
        s1_rcr <= cr_in * K_RCR;
        s1_gcb <= cb_in * K_GCB;
        s1_gcr <= cr_in * K_GCR;
        s1_bcb <= cb_in * K_BCB;
      end
    end
  end

  // Stage 2: sum, floor shift and clamp straight into the FIFO write port.
  assign r_sum   = s1_y + s1_rcr;
  assign g_sum   = s1_y - s1_gcb - s1_gcr;
  assign b_sum   = s1_y + s1_bcb;
  assign push_px = {clamp(r_sum >>> 8), clamp(g_sum >>> 8), clamp(b_sum >>> 8)};
`endif

  logic [PXW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_n;
  logic [CW:0]    inflight_n;
  logic           push, pop, empty, ready_n;
  logic [PXW-1:0] head;

  assign push       = s1_v;
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign count_n    = count + CW'(push) - CW'(pop);
  // Room is reserved for the pixel in stage 1, so a push can never find the FIFO full.
  assign inflight_n = (CW+1)'(count_n) + (CW+1)'(accept);
  assign ready_n    = (inflight_n < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= push_px;
  end

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      YCC_READY <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      YCC_READY <= ready_n;
    end
  end

  state_t         state, state_n;
  logic [2*DW-1:0] pix;
  logic           dhsyn_n;
  logic [DW-1:0]  dvd_n;

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      IMG_DHSYN <= 1'b0;
      IMG_DVD   <= '0;
      pix       <= '0;
    end else begin
      state     <= state_n;
      IMG_DHSYN <= dhsyn_n;
      IMG_DVD   <= dvd_n;
      if (pop) pix <= head[2*DW-1:0];
    end
  end

  // Serializer: pop on entry to SR, then G and B come from the held pixel.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    dvd_n   = '0;
    case (state)
      IDLE: if (!empty) begin
        state_n = SR;
        pop     = 1'b1;
      end
      SR: state_n = SG;
      SG: state_n = SB;
      SB: if (!empty) begin
        state_n = SR;
        pop     = 1'b1;
      end else begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      SR:      dvd_n = head[PXW-1:2*DW];
      SG:      dvd_n = pix[2*DW-1:DW];
      SB:      dvd_n = pix[DW-1:0];
      default: dvd_n = '0;
    endcase
    dhsyn_n = (state_n != IDLE);
  end

  // Frame envelope; vs_d resets high so a level-high VSYNC after reset is not a new frame.
  logic vs_d;
  logic frame_end;

  assign frame_end = !YCC_VSYNC && !s1_v && empty && (state == IDLE);

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      vs_d      <= 1'b1;
      IMG_DVSYN <= 1'b0;
    end else begin
      vs_d <= YCC_VSYNC;
      if (YCC_VSYNC && !vs_d) IMG_DVSYN <= 1'b1;
      else if (frame_end)     IMG_DVSYN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ycc2rgb_ser.sv
// Self-checking bench for ycc2rgb_ser: directed and random pixels against an integer reference model.
module tb_ycc2rgb_ser;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync, dvalid;
  logic [DW-1:0] y, cb, cr;
  logic          ready, dvsyn, dhsyn;
  logic [DW-1:0] dvd;

  int n_tests = 0, n_fail = 0;
  int n_bytes = 0, n_runs = 0, n_acc = 0, max_out = 0;
  int cyc = 0, last_byte_cyc = 0;
  bit prev_dh = 1'b0, throttled = 1'b0;
  logic [7:0] exp_q[$];

  ycc2rgb_ser #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK(clk), .RST(rst), .YCC_VSYNC(vsync), .YCC_DVALID(dvalid),
    .Y_DAT(y), .Cb_DAT(cb), .Cr_DAT(cr), .YCC_READY(ready),
    .IMG_DVSYN(dvsyn), .IMG_DHSYN(dhsyn), .IMG_DVD(dvd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [23:0] ref_rgb(input int py, input int pcb, input int pcr);
    int r, g, b;
`ifdef YCC2RGB_GRAY_EN
    r = py; g = py; b = py;
`else
    r = clamp8((256 * py + 359 * (pcr - 128)) >>> 8);
    g = clamp8((256 * py - 88 * (pcb - 128) - 183 * (pcr - 128)) >>> 8);
    b = clamp8((256 * py + 454 * (pcb - 128)) >>> 8);
`endif
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Output monitor: every byte against the model queue, idle data must be zero.
  always @(negedge clk) begin
    if (rst) begin
      prev_dh = 1'b0;
    end else begin
      if (dhsyn) begin
        if (!prev_dh) n_runs++;
        chk("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("byte_value", 32'(dvd), 32'(exp_q.pop_front()));
        n_bytes++;
        last_byte_cyc = cyc;
      end else begin
        chk("dvd_idle_zero", 32'(dvd), 0);
      end
      if (n_acc - n_bytes / 3 > max_out) max_out = n_acc - n_bytes / 3;
      prev_dh = dhsyn;
    end
  end

  // Called at a negedge; leaves DVALID high and returns one negedge after the accepting edge.
  task automatic send_px(input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
    int k = 0;
    logic [23:0] e;
    y = py; cb = pcb; cr = pcr; dvalid = 1'b1;
    while (!ready && k < 200) begin
      throttled = 1'b1;
      @(negedge clk);
      k++;
    end
    if (ready && vsync) begin
      e = ref_rgb(int'(py), int'(pcb), int'(pcr));
      exp_q.push_back(e[23:16]);
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[7:0]);
      n_acc++;
    end else begin
      chk("send_ready_timeout", 32'(ready), 1);
    end
    @(negedge clk);
  endtask

  task automatic get_px(output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    int k = 0;
    while (!dhsyn && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("get_px_timeout", 32'(dhsyn), 1);
    r = dvd; @(negedge clk);
    g = dvd; @(negedge clk);
    b = dvd;
  endtask

  task automatic wait_dvsyn_low(input string tag);
    int k = 0;
    while (dvsyn && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(dvsyn), 0);
  endtask

  initial begin
    logic [7:0] r, g, b;
    int b0, runs0, lows, fall_cyc, highs_v, highs_h;

    rst = 1'b1; vsync = 1'b0; dvalid = 1'b0; y = '0; cb = '0; cr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_dvsyn", 32'(dvsyn), 0);
    chk("rst_dhsyn", 32'(dhsyn), 0);
    chk("rst_dvd", 32'(dvd), 0);
    rst = 1'b0;
    #1 chk("ready_before_edge", 32'(ready), 0);
    @(negedge clk);
    chk("ready_first_edge", 32'(ready), 1);
    chk("dvsyn_idle", 32'(dvsyn), 0);
    vsync = 1'b1;
    @(negedge clk);
    chk("dvsyn_rise", 32'(dvsyn), 1);

    // Mid-grey single pixel with exact latency and a 3-cycle byte window.
    send_px(8'h80, 8'h80, 8'h80);
    dvalid = 1'b0;
    chk("lat_c1_dh", 32'(dhsyn), 0);
    @(negedge clk); chk("lat_c2_dh", 32'(dhsyn), 0);
    @(negedge clk); chk("lat_c3_dh", 32'(dhsyn), 1); chk("lat_c3_r", 32'(dvd), 32'h80);
    @(negedge clk); chk("lat_c4_dh", 32'(dhsyn), 1); chk("lat_c4_g", 32'(dvd), 32'h80);
    @(negedge clk); chk("lat_c5_dh", 32'(dhsyn), 1); chk("lat_c5_b", 32'(dvd), 32'h80);
    @(negedge clk); chk("lat_c6_dh", 32'(dhsyn), 0);

    // Clamping corners and a mixed pixel.
    send_px(8'h00, 8'h00, 8'h00); dvalid = 1'b0;
    get_px(r, g, b);
`ifdef YCC2RGB_GRAY_EN
    chk("zero_r", 32'(r), 32'h00); chk("zero_g", 32'(g), 32'h00); chk("zero_b", 32'(b), 32'h00);
`else
    chk("zero_r", 32'(r), 32'h00); chk("zero_g", 32'(g), 32'h87); chk("zero_b", 32'(b), 32'h00);
`endif
    @(negedge clk);
    send_px(8'hFF, 8'h80, 8'hFF); dvalid = 1'b0;
    get_px(r, g, b);
`ifdef YCC2RGB_GRAY_EN
    chk("sat_r", 32'(r), 32'hFF); chk("sat_g", 32'(g), 32'hFF); chk("sat_b", 32'(b), 32'hFF);
`else
    chk("sat_r", 32'(r), 32'hFF); chk("sat_g", 32'(g), 32'hA4); chk("sat_b", 32'(b), 32'hFF);
`endif
    @(negedge clk);
    send_px(8'h5A, 8'h10, 8'hF0); dvalid = 1'b0;
    get_px(r, g, b);
`ifdef YCC2RGB_GRAY_EN
    chk("mix_r", 32'(r), 32'h5A); chk("mix_g", 32'(g), 32'h5A); chk("mix_b", 32'(b), 32'h5A);
`else
    chk("mix_r", 32'(r), 32'hF7); chk("mix_g", 32'(g), 32'h30); chk("mix_b", 32'(b), 32'h00);
`endif
    repeat (4) @(negedge clk);

    // Burst of 20 with DVALID held: throttling, one contiguous run of 60 bytes.
    b0 = n_bytes; runs0 = n_runs; throttled = 1'b0; max_out = 0;
    for (int i = 0; i < 20; i++) send_px(8'($urandom), 8'($urandom), 8'($urandom));
    dvalid = 1'b0;
    for (int k = 0; k < 400 && n_bytes < b0 + 60; k++) @(negedge clk);
    chk("burst_bytes", 32'(n_bytes - b0), 60);
    chk("burst_one_run", 32'(n_runs - runs0), 1);
    chk("burst_throttled", 32'(throttled), 1);
    chk("occupancy_bound", 32'(max_out <= int'(DEPTH) + 1), 1);
    repeat (4) @(negedge clk);

    // Frame merge: a short VSYNC low with pixels pending keeps DVSYN high.
    b0 = n_bytes; lows = 0;
    for (int i = 0; i < 3; i++) send_px(8'($urandom), 8'($urandom), 8'($urandom));
    dvalid = 1'b0; vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    if (!dvsyn) lows++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!dvsyn) lows++;
    end
    chk("merge_dvsyn_low_cycles", 32'(lows), 0);
    chk("merge_bytes", 32'(n_bytes - b0), 9);

    // VSYNC falls with 4 pixels pending: DVSYN covers the last B byte.
    b0 = n_bytes;
    for (int i = 0; i < 4; i++) send_px(8'($urandom), 8'($urandom), 8'($urandom));
    dvalid = 1'b0; vsync = 1'b0;
    chk("pend_dvsyn_high", 32'(dvsyn), 1);
    wait_dvsyn_low("pend_dvsyn_fall_timeout");
    fall_cyc = cyc;
    chk("pend_bytes", 32'(n_bytes - b0), 12);
    chk("pend_fall_cycle", 32'(fall_cyc), 32'(last_byte_cyc + 2));

    // Random pixels with random gaps.
    vsync = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send_px(8'($urandom), 8'($urandom), 8'($urandom));
      dvalid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    vsync = 1'b0;
    wait_dvsyn_low("rand_dvsyn_fall_timeout");
    chk("rand_queue_drained", 32'(exp_q.size()), 0);

    // Reset during SG with VSYNC high.
    vsync = 1'b1;
    @(negedge clk);
    send_px(8'($urandom), 8'($urandom), 8'($urandom));
    dvalid = 1'b0;
    for (int k = 0; k < 60 && !dhsyn; k++) @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_sg", 32'(dhsyn), 1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_dvsyn", 32'(dvsyn), 0);
    chk("midrst_dhsyn", 32'(dhsyn), 0);
    chk("midrst_dvd", 32'(dvd), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    highs_v = 0; highs_h = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dvsyn) highs_v++;
      if (dhsyn) highs_h++;
    end
    chk("postrst_dvsyn_low", 32'(highs_v), 0);
    chk("postrst_no_bytes", 32'(highs_h), 0);
    chk("postrst_ready", 32'(ready), 1);
    vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    chk("postrst_dvsyn_rise", 32'(dvsyn), 1);
    send_px(8'h5A, 8'h10, 8'hF0); dvalid = 1'b0;
    get_px(r, g, b);
`ifdef YCC2RGB_GRAY_EN
    chk("postrst_r", 32'(r), 32'h5A); chk("postrst_g", 32'(g), 32'h5A); chk("postrst_b", 32'(b), 32'h5A);
`else
    chk("postrst_r", 32'(r), 32'hF7); chk("postrst_g", 32'(g), 32'h30); chk("postrst_b", 32'(b), 32'h00);
`endif
    vsync = 1'b0;
    wait_dvsyn_low("final_dvsyn_fall_timeout");
    chk("final_queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ycc2rgb_ser.md
YCC2RGB_SER -- requirements
Module: ycc2rgb_ser

Interface
REQ-001 SHALL have parameter DW, default 8, per-channel sample width; all arithmetic rules below are stated for DW=8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO depth in pixels, power of two, at least 4.
REQ-003 CLOCK  in  1  single clock; all logic on its rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 YCC_VSYNC  in  1  input frame-valid level.
REQ-006 YCC_DVALID  in  1  input pixel valid.
REQ-007 Y_DAT, Cb_DAT, Cr_DAT  in  DW each  input pixel components.
REQ-008 YCC_READY  out  1  block can accept a pixel this cycle.
REQ-009 IMG_DVSYN  out  1  output frame-valid level.
REQ-010 IMG_DHSYN  out  1  output byte valid.
REQ-011 IMG_DVD  out  DW  byte-serial output data, order R, G, B.

Function
REQ-012 Pixel SHALL be accepted only on a cycle where YCC_DVALID, YCC_READY and YCC_VSYNC are all high; DVALID while VSYNC is low is ignored.
REQ-013 Conversion SHALL use integer coefficients: R=(256Y+359(Cr-128))>>>8, G=(256Y-88(Cb-128)-183(Cr-128))>>>8, B=(256Y+454(Cb-128))>>>8, signed 19-bit intermediate, arithmetic shift (floor), each result clamped to 0..255.
REQ-014 Conversion SHALL be a 2-stage pipeline (stage 1 products, stage 2 sum/shift/clamp) writing into the pixel FIFO.
REQ-015 YCC_READY SHALL be high iff FIFO occupancy plus pixels in the pipeline is less than FIFO_DEPTH; it SHALL be driven from registers only.
REQ-016 FIFO SHALL support simultaneous push and pop with occupancy unchanged, SHALL never overflow, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Serializer FSM states are IDLE, SR, SG, SB.
- IDLE->SR when FIFO is not empty; pop on entry to SR.
- SR->SG->SB unconditionally.
- SB->SR when FIFO is not empty (pop), else SB->IDLE.
REQ-018 IMG_DHSYN SHALL be high exactly in SR/SG/SB cycles, with IMG_DVD holding R, G, B respectively; back-to-back pixels SHALL produce no gap.
REQ-019 Latency: a pixel accepted at cycle 0 into an empty block SHALL emit R at cycle 3, G at cycle 4 and B at cycle 5.
REQ-020 IMG_DVSYN SHALL rise one cycle after a YCC_VSYNC rising edge.
REQ-021 IMG_DVSYN SHALL fall one cycle after the first cycle on which YCC_VSYNC is low, the pipeline is empty, the FIFO is empty and the FSM is IDLE, so the last B byte is always inside the frame.
REQ-022 A new YCC_VSYNC rising edge while IMG_DVSYN is still high SHALL keep IMG_DVSYN high (frames merge) and SHALL drop no pixel.
REQ-023 IMG_DVD SHALL be 0 whenever IMG_DHSYN is low.

Reset
REQ-024 While RST is high: YCC_READY=0, IMG_DVSYN=0, IMG_DHSYN=0, IMG_DVD=0, FSM=IDLE, FIFO empty, pipeline valids cleared.
REQ-025 Reset mid-frame or mid-pixel SHALL discard all in-flight data; after RST falls, IMG_DVSYN SHALL stay low until the next YCC_VSYNC rising edge even if YCC_VSYNC is already high.
REQ-026 YCC_READY SHALL go high on the first clock edge after RST is released.

Configuration
REQ-027 Macro YCC2RGB_GRAY_EN: when defined, R=G=B=Y, no multipliers are synthesized, and latency and timing are identical to REQ-019.
REQ-028 When YCC2RGB_GRAY_EN is not defined, conversion SHALL follow the full matrix of REQ-013.

Verification
REQ-029 Single pixel Y=128, Cb=128, Cr=128 -> bytes 80,80,80 hex at cycles 3,4,5 with IMG_DHSYN high for exactly 3 cycles.
REQ-030 Pixel Y=0, Cb=0, Cr=0 -> bytes 00,87,00; pixel Y=255, Cb=128, Cr=255 -> R clamps to FF (build without macro).
REQ-031 DVALID held high for 20 pixels -> YCC_READY throttles, no loss, 60 contiguous bytes in order, FIFO occupancy never exceeds FIFO_DEPTH.
REQ-032 VSYNC falls while 4 pixels are pending -> IMG_DVSYN stays high until one cycle after the last B byte.
REQ-033 RST pulsed during SG with YCC_VSYNC high -> all outputs 0, IMG_DVSYN low until the next VSYNC rising edge.
REQ-034 Build with YCC2RGB_GRAY_EN, input Y=5A, Cb=10, Cr=F0 -> bytes 5A,5A,5A.
